// File: rtl/msrv32_dmem_pkg.sv
// msrv32_dmem_pkg
// Shared encodings for the data-memory access sequencer:
//   - access size codes coming from the memory stage (byte/half/word)
//   - AHB-Lite HTRANS / HSIZE constants
//   - sequencer state enum and the captured-request record
//   - alignment and size-translation helpers
package msrv32_dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;  // any 1x code means word

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, ERR} dmem_state_e;

  // Request as captured on the IDLE->ADDR transition.
  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
  } dmem_req_t;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    if (size[1]) return lo != 2'b00;
    if (size[0]) return lo[0];
    return 1'b0;
  endfunction

  function automatic logic [2:0] to_hsize(input logic [1:0] size);
    if (size[1]) return HSIZE_WORD;
    if (size[0]) return HSIZE_HALF;
    return HSIZE_BYTE;
  endfunction

endpackage

// File: rtl/msrv32_store_align.sv
// msrv32_store_align
// Combinational store lane steering: turns a right-aligned store value into
// AHB byte strobes and lane-replicated write data.
//   size_in     : 00 byte, 01 half, 1x word
//   addr_lo_in  : byte address bits [1:0] (assumed already alignment-checked)
//   wdata_in    : right-aligned store data
//   hwstrb_out  : byte strobes
//   hwdata_out  : replicated write data
module msrv32_store_align (
  input  logic [1:0]  size_in,
  input  logic [1:0]  addr_lo_in,
  input  logic [31:0] wdata_in,
  output logic [3:0]  hwstrb_out,
  output logic [31:0] hwdata_out
);

  always_comb begin
    hwstrb_out = 4'b1111;
    hwdata_out = wdata_in;
    if (!size_in[1]) begin
      if (size_in[0]) begin
        hwstrb_out = 4'b0011 << addr_lo_in;
        hwdata_out = {2{wdata_in[15:0]}};
      end else begin
        hwstrb_out = 4'b0001 << addr_lo_in;
        hwdata_out = {4{wdata_in[7:0]}};
      end
    end
  end

endmodule

// File: rtl/msrv32_dmem_ctrl.sv
// msrv32_dmem_ctrl
// Data-memory access sequencer between the memory stage and an AHB-Lite bus.
// One outstanding transfer; IDLE -> ADDR -> DATA (-> ERR) -> IDLE.
//   Pipeline side : req_in/wr_in/addr_in/wdata_in/size_in/unsigned_in in,
//                   stall_out, done_out, misaligned_out, bus_err_out out
//   AHB side      : haddr/htrans/hwrite/hsize/hwdata/hwstrb out,
//                   hready_in, hresp_in in
//   Load unit     : load_size_out, ladder_out, load_unsigned_out (captured
//                   at request), ahb_resp_out (hresp during DATA/ERR)
// A hready-low watchdog aborts the transfer after TIMEOUT_CYCLES cycles.
module msrv32_dmem_ctrl
  import msrv32_dmem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 5
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        req_in,
  input  logic        wr_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  input  logic [1:0]  size_in,
  input  logic        unsigned_in,
  output logic        stall_out,
  output logic        done_out,
  output logic        misaligned_out,
  output logic        bus_err_out,
  output logic [31:0] haddr_out,
  output logic [1:0]  htrans_out,
  output logic        hwrite_out,
  output logic [2:0]  hsize_out,
  output logic [31:0] hwdata_out,
  output logic [3:0]  hwstrb_out,
  input  logic        hready_in,
  input  logic        hresp_in,
  output logic [1:0]  load_size_out,
  output logic [1:0]  ladder_out,
  output logic        load_unsigned_out,
  output logic        ahb_resp_out
);

  dmem_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  dmem_req_t        req_q, req_d;
  logic [1:0]       load_size_q, load_size_d;

  logic        misaligned;
  logic        timeout;
  logic [3:0]  st_strb;
  logic [31:0] st_data;

  assign misaligned = is_misaligned(size_in, addr_in[1:0]);
  // Counter holds the number of consecutive hready-low cycles already spent
  // in the current state; reaching the limit aborts regardless of hready.
  assign timeout    = (state_q != IDLE) && (cnt_q == CNT_W'(TIMEOUT_CYCLES));

  msrv32_store_align u_store_align (
    .size_in    (req_q.size),
    .addr_lo_in (req_q.addr[1:0]),
    .wdata_in   (req_q.wdata),
    .hwstrb_out (st_strb),
    .hwdata_out (st_data)
  );

  always_comb begin
    state_d        = state_q;
    req_d          = req_q;
    load_size_d    = load_size_q;
    stall_out      = 1'b0;
    done_out       = 1'b0;
    misaligned_out = 1'b0;
    bus_err_out    = 1'b0;
    htrans_out     = HTRANS_IDLE;
    case (state_q)
      IDLE: begin
        if (req_in) begin
          if (misaligned) begin
            misaligned_out = 1'b1;
          end else begin
            stall_out   = 1'b1;
            req_d.wr    = wr_in;
            req_d.addr  = addr_in;
            req_d.wdata = wdata_in;
            req_d.size  = size_in;
            req_d.uns   = unsigned_in;
            load_size_d = size_in[1] ? 2'b11 : size_in;
            state_d     = ADDR;
          end
        end
      end
      ADDR: begin
        stall_out = 1'b1;
        if (timeout) begin
          bus_err_out = 1'b1;
          state_d     = IDLE;
        end else begin
          htrans_out = HTRANS_NONSEQ;
          if (hready_in) state_d = DATA;
        end
      end
      DATA: begin
        if (timeout) begin
          stall_out   = 1'b1;
          bus_err_out = 1'b1;
          state_d     = IDLE;
        end else if (hready_in) begin
          // hresp with hready high is the tail of an error response that
          // skipped the first cycle; report it as an error, not a completion.
          if (hresp_in) begin
            stall_out   = 1'b1;
            bus_err_out = 1'b1;
          end else begin
            done_out = 1'b1;
          end
          state_d = IDLE;
        end else begin
          stall_out = 1'b1;
          if (hresp_in) state_d = ERR;
        end
      end
      ERR: begin
        stall_out = 1'b1;
        if (timeout || hready_in) begin
          bus_err_out = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = '0;
    if (state_q != IDLE && state_d == state_q && !hready_in) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_q       <= '0;
      load_size_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      load_size_q <= load_size_d;
    end
  end

  assign haddr_out  = (state_q == ADDR) ? req_q.addr : 32'd0;
  assign hwrite_out = (state_q == ADDR) && req_q.wr;
  assign hsize_out  = (state_q == ADDR) ? to_hsize(req_q.size) : 3'b000;
  assign hwdata_out = (state_q == DATA && req_q.wr) ? st_data : 32'd0;
  assign hwstrb_out = (state_q == DATA && req_q.wr) ? st_strb : 4'b0000;

  assign load_size_out     = load_size_q;
  assign ladder_out        = req_q.addr[1:0];
  assign load_unsigned_out = req_q.uns;
  assign ahb_resp_out      = (state_q == DATA || state_q == ERR) && hresp_in;

endmodule

// File: tb/tb_msrv32_dmem_ctrl.sv
// Scoreboard bench for msrv32_dmem_ctrl. The driver scripts bus behaviour per
// transfer (address/data wait states, error, timeout), predicts the response
// cycle and payload from the access rules, and queues it; a negedge monitor
// checks per-cycle stall/htrans/ahb_resp and pops the queue on each response.
module tb_msrv32_dmem_ctrl;

  localparam int TO     = 16;
  localparam int K_DONE = 0;
  localparam int K_MIS  = 1;
  localparam int K_ERR  = 2;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        req_in = 1'b0, wr_in = 1'b0, unsigned_in = 1'b0;
  logic [31:0] addr_in = '0, wdata_in = '0;
  logic [1:0]  size_in = '0;
  logic        hready_in = 1'b1, hresp_in = 1'b0;
  logic        stall_out, done_out, misaligned_out, bus_err_out;
  logic [31:0] haddr_out, hwdata_out;
  logic [1:0]  htrans_out, load_size_out, ladder_out;
  logic        hwrite_out, load_unsigned_out, ahb_resp_out;
  logic [2:0]  hsize_out;
  logic [3:0]  hwstrb_out;

  msrv32_dmem_ctrl #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .req_in(req_in), .wr_in(wr_in),
    .addr_in(addr_in), .wdata_in(wdata_in), .size_in(size_in),
    .unsigned_in(unsigned_in), .stall_out(stall_out), .done_out(done_out),
    .misaligned_out(misaligned_out), .bus_err_out(bus_err_out),
    .haddr_out(haddr_out), .htrans_out(htrans_out), .hwrite_out(hwrite_out),
    .hsize_out(hsize_out), .hwdata_out(hwdata_out), .hwstrb_out(hwstrb_out),
    .hready_in(hready_in), .hresp_in(hresp_in), .load_size_out(load_size_out),
    .ladder_out(ladder_out), .load_unsigned_out(load_unsigned_out),
    .ahb_resp_out(ahb_resp_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    int          kind;
    int          cyc;
    bit          eresp;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        uns;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   chk_en = 1'b0;
  logic       exp_stall = 1'b0, exp_ahb = 1'b0;
  logic [1:0] exp_htrans = 2'b00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Reference store lane model: lane b carries byte (b mod nbytes) of the data
  // and is strobed when it falls inside [addr, addr+nbytes).
  function automatic logic [35:0] store_model(input logic w, input logic [1:0] sz,
                                              input logic [31:0] a, input logic [31:0] d);
    logic [3:0]  s;
    logic [31:0] v;
    int nb, base;
    nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    base = int'(a[1:0]);
    s = '0;
    v = '0;
    for (int b = 0; b < 4; b++) begin
      if (w) begin
        s[b]       = (b >= base) && (b < base + nb);
        v[8*b +: 8] = d[8*(b % nb) +: 8];
      end
    end
    return {s, v};
  endfunction

  always @(negedge clk_in) begin
    exp_t e;
    logic any;
    logic [35:0] sm;
    if (chk_en) begin
      any = done_out | misaligned_out | bus_err_out;
      chk("stall", 32'(stall_out), 32'(exp_stall));
      chk("htrans", 32'(htrans_out), 32'(exp_htrans));
      chk("ahb_resp", 32'(ahb_resp_out), 32'(exp_ahb));
      if (exp_htrans == 2'b10 && sbq.size() > 0) begin
        chk("haddr", haddr_out, sbq[0].addr);
        chk("hwrite", 32'(hwrite_out), 32'(sbq[0].wr));
        chk("hsize", 32'(hsize_out), sbq[0].size[1] ? 32'd2 : 32'(sbq[0].size));
      end
      if (sbq.size() > 0 && cyc == sbq[0].cyc) begin
        e = sbq.pop_front();
        chk("resp_pulse", 32'(any), 32'd1);
        if (any) begin
          chk("pulse_excl", 32'(int'(done_out) + int'(misaligned_out) + int'(bus_err_out)), 32'd1);
          chk("resp_kind", done_out ? 32'd0 : misaligned_out ? 32'd1 : 32'd2, 32'(e.kind));
          if (e.kind != K_MIS) begin
            chk("load_size", 32'(load_size_out), e.size[1] ? 32'd3 : 32'(e.size));
            chk("ladder", 32'(ladder_out), 32'(e.addr[1:0]));
            chk("load_uns", 32'(load_unsigned_out), 32'(e.uns));
          end
          if (e.kind == K_DONE) begin
            sm = store_model(e.wr, e.size, e.addr, e.wdata);
            chk("hwstrb", 32'(hwstrb_out), 32'(sm[35:32]));
            chk("hwdata", hwdata_out, sm[31:0]);
          end
        end
      end else if (any) begin
        chk("spurious_pulse", 32'(any), 32'd0);
      end
    end
  end

  task automatic rand_payload();
    wr_in       = 1'($urandom_range(0, 1));
    addr_in     = $urandom;
    wdata_in    = $urandom;
    size_in     = 2'($urandom_range(0, 3));
    unsigned_in = 1'($urandom_range(0, 1));
  endtask

  task automatic gap(input int n);
    for (int g = 0; g < n; g++) begin
      req_in = 1'b0;
      rand_payload();
      hready_in  = 1'($urandom_range(0, 1));
      hresp_in   = 1'($urandom_range(0, 1));
      exp_stall  = 1'b0;
      exp_htrans = 2'b00;
      exp_ahb    = 1'b0;
      @(posedge clk_in); #1;
    end
  endtask

  // wa: address-phase wait cycles, wd: data-phase wait cycles (>=TO means
  // hready never returns in that phase), er: two-cycle error response.
  task automatic run_txn(input logic w, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] d, input logic u, input int wa,
                         input int wd, input bit er);
    exp_t e;
    bit mis;
    int ro, dstart;
    mis    = (sz == 2'd1 && a[0]) || (sz[1] && a[1:0] != 2'd0);
    dstart = wa + 2;
    if (mis)           begin ro = 0;           e.kind = K_MIS; end
    else if (wa >= TO) begin ro = TO + 1;      e.kind = K_ERR; end
    else if (wd >= TO) begin ro = dstart + TO; e.kind = K_ERR; end
    else begin
      ro     = dstart + wd + (er ? 1 : 0);
      e.kind = er ? K_ERR : K_DONE;
    end
    e.eresp = !mis && wa < TO && wd < TO && er;
    e.cyc = cyc + ro;
    e.wr = w; e.size = sz; e.addr = a; e.wdata = d; e.uns = u;
    sbq.push_back(e);
    for (int o = 0; o <= ro; o++) begin
      exp_ahb = 1'b0;
      if (o == 0) begin
        req_in = 1'b1; wr_in = w; addr_in = a; wdata_in = d; size_in = sz; unsigned_in = u;
        hready_in = 1'($urandom_range(0, 1));
        hresp_in  = 1'($urandom_range(0, 1));
      end else begin
        rand_payload();
        if (o < dstart) begin
          hready_in = (wa < TO) && (o == wa + 1);
          hresp_in  = 1'($urandom_range(0, 1));
        end else begin
          if (o < dstart + wd)       begin hready_in = 1'b0; hresp_in = 1'b0; end
          else if (o == dstart + wd) begin hready_in = !er;  hresp_in = er;   end
          else                       begin hready_in = 1'b1; hresp_in = 1'b1; end
          exp_ahb = hresp_in;
        end
      end
      exp_htrans = (!mis && o >= 1 && o < dstart && o <= TO) ? 2'b10 : 2'b00;
      exp_stall  = mis ? 1'b0 : (o < ro) ? 1'b1 : (e.kind != K_DONE);
      @(posedge clk_in); #1;
    end
    req_in = 1'b0; hresp_in = 1'b0;
    exp_stall = 1'b0; exp_htrans = 2'b00; exp_ahb = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_stall"}, 32'(stall_out), 32'd0);
    chk({tag, "_pulses"}, 32'({done_out, misaligned_out, bus_err_out}), 32'd0);
    chk({tag, "_htrans"}, 32'(htrans_out), 32'd0);
    chk({tag, "_haddr"}, haddr_out, 32'd0);
    chk({tag, "_hwr_hsz"}, 32'({hwrite_out, hsize_out}), 32'd0);
    chk({tag, "_hwstrb"}, 32'(hwstrb_out), 32'd0);
    chk({tag, "_hwdata"}, hwdata_out, 32'd0);
    chk({tag, "_loadu"}, 32'({load_size_out, ladder_out, load_unsigned_out}), 32'd0);
    chk({tag, "_ahbresp"}, 32'(ahb_resp_out), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d pending responses", sbq.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int wa, wd, r;
    logic [31:0] a;
    hresp_in = 1'b1;
    #12;
    check_zero("reset");
    hresp_in = 1'b0;
    @(posedge clk_in); #1;
    rst_n_in = 1'b1;
    chk_en   = 1'b1;
    gap(1);

    // directed
    run_txn(1'b0, 2'b10, 32'h0000_1000, 32'h0, 1'b0, 0, 0, 1'b0);
    gap(1);
    run_txn(1'b1, 2'b00, 32'h0000_2003, 32'h0000_00AB, 1'b0, 0, 3, 1'b0);
    run_txn(1'b0, 2'b01, 32'h0000_3001, 32'h0, 1'b0, 0, 0, 1'b0);
    gap(1);
    run_txn(1'b0, 2'b00, 32'h0000_4002, 32'h0, 1'b0, 0, 0, 1'b1);
    gap(1);
    run_txn(1'b0, 2'b10, 32'h0000_5000, 32'h0, 1'b0, 16, 0, 1'b0);
    gap(2);
    run_txn(1'b1, 2'b01, 32'h0000_6002, 32'h1234_5678, 1'b1, 1, 16, 1'b0);
    gap(1);

    // reset in the middle of a store data phase
    chk_en = 1'b0;
    req_in = 1'b1; wr_in = 1'b1; size_in = 2'b10; addr_in = 32'h0000_7004;
    wdata_in = 32'hDEAD_BEEF; hready_in = 1'b1; hresp_in = 1'b0;
    @(posedge clk_in); #1;
    hready_in = 1'b1;
    @(posedge clk_in); #1;
    hready_in = 1'b0;
    #2;
    chk("pre_rst_hwstrb", 32'(hwstrb_out), 32'hF);
    rst_n_in = 1'b0; req_in = 1'b0; hresp_in = 1'b1;
    #1;
    check_zero("midrst");
    @(posedge clk_in); #1;
    rst_n_in = 1'b1; hready_in = 1'b1; hresp_in = 1'b0;
    chk_en = 1'b1;
    run_txn(1'b0, 2'b11, 32'h0000_8008, 32'h0, 1'b1, 0, 0, 1'b0);
    gap(1);

    // randomized
    for (int i = 0; i < 300; i++) begin
      r  = int'($urandom_range(0, 19));
      wa = (r == 0) ? int'($urandom_range(16, 18)) : int'($urandom_range(0, 2));
      wd = (r == 1) ? int'($urandom_range(16, 18)) : int'($urandom_range(0, 3));
      a  = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      run_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, $urandom,
              1'($urandom_range(0, 1)), wa, wd, ($urandom_range(0, 5) == 0));
      gap(int'($urandom_range(0, 2)));
    end

    gap(2);
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/msrv32_dmem_ctrl.md
Name: msrv32_dmem_ctrl

Overview:
- Data-memory access sequencer between the pipeline's memory stage and an AHB-Lite data bus; one outstanding transfer at a time.
- Checks alignment and drives the address and data phases.
- Generates store strobes and replicated write data.
- Supplies the load unit with its control inputs (size, address low bits, unsigned, bus response) for the data phase.
- Stalls the pipeline until completion, error or timeout.

Parameters:
- TIMEOUT_CYCLES, 16, consecutive hready-low cycles in ADDR/DATA/ERR before the transfer is aborted (minimum 2).
- CNT_W, 5, timeout counter width; must hold TIMEOUT_CYCLES.

Ports:
- clk_in  input  1  clock
- rst_n_in  input  1  reset, asynchronous, active-low
- req_in  input  1  pipeline access request; held until stall_out drops
- wr_in  input  1  1=store, 0=load
- addr_in  input  32  byte address
- wdata_in  input  32  store data, right-aligned
- size_in  input  2  00 byte, 01 half, 1x word
- unsigned_in  input  1  load zero-extend select
- stall_out  output  1  freeze pipeline
- done_out  output  1  one-cycle completion pulse
- misaligned_out  output  1  one-cycle misaligned-access pulse
- bus_err_out  output  1  one-cycle bus error/timeout pulse
- haddr_out  output  32  AHB address
- htrans_out  output  2  00 IDLE, 10 NONSEQ
- hwrite_out  output  1  AHB write
- hsize_out  output  3  000/001/010
- hwdata_out  output  32  AHB write data
- hwstrb_out  output  4  byte strobes
- hready_in  input  1  AHB ready
- hresp_in  input  1  AHB error response
- load_size_out  output  2  to load unit: 00 byte, 01 half, 11 word
- ladder_out  output  2  to load unit: captured addr[1:0]
- load_unsigned_out  output  1  to load unit
- ahb_resp_out  output  1  to load unit: hresp_in in DATA/ERR, else 0

Behaviour:
- Reset (async, rst_n_in low): state IDLE, counter 0, all registered outputs 0, htrans_out 00. Reset mid-transfer aborts immediately; no done/err pulse.
- States:
  - IDLE: if req_in is high and the access is aligned, capture the request and go to ADDR.
  - Misaligned request (half with addr[0]=1, or word with addr[1:0]!=0): misaligned_out=1 in that cycle, no bus activity, stall_out=0, stay in IDLE.
  - ADDR: htrans_out=10 with haddr/hwrite/hsize from captured values. hready_in=1 -> DATA; else hold.
  - DATA: htrans_out=00; hwdata_out/hwstrb_out valid. Then:
    - hready_in=1, hresp_in=0 -> done_out=1, go to IDLE.
    - hresp_in=1, hready_in=0 -> ERR.
    - hready_in=0, hresp_in=0 -> wait.
  - ERR: hready_in=1 -> bus_err_out=1, go to IDLE.
- Timeout: the counter increments each ADDR/DATA/ERR cycle with hready_in=0 and clears on state change. On reaching TIMEOUT_CYCLES: bus_err_out=1, htrans_out=00, go to IDLE.
- done_out, misaligned_out and bus_err_out are combinational from state plus inputs, mutually exclusive, and never high for two consecutive cycles from the same request.
- stall_out = (IDLE & req_in & aligned) | ADDR | ERR | (DATA & !done_out).
- Latency with zero wait states: req sampled at cycle 0 IDLE, ADDR at cycle 1, DATA plus done_out at cycle 2. Load data (hrdata to load unit) is valid when done_out=1.
- Load-unit outputs are registered at capture and held stable from ADDR through DATA. load_size_out maps size 1x to 11.
- Stores:
  - hwstrb_out: byte 0001<<addr[1:0], half 0011<<addr[1:0], word 1111.
  - hwdata_out: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
- Loads: hwstrb_out=0000, hwdata_out=0.
- req_in outside IDLE is ignored.

Decomposition:
- Package msrv32_dmem_pkg: size encodings (byte/half/word), HTRANS_IDLE/NONSEQ, HSIZE constants, state enum {IDLE, ADDR, DATA, ERR}.
- Sub-module msrv32_store_align (combinational): size + addr[1:0] + wdata -> hwstrb, hwdata. Reused by any future store path.

Test Plan:
- Load word 0x0000_1000, hready always 1 -> htrans 10 at cycle 1, done_out at cycle 2, load_size_out=11, ladder_out=00, stall_out=1 at cycles 0-1 and 0 at cycle 2.
- Store byte 0xAB to 0x0000_2003, hready low 3 cycles in DATA -> hwstrb=1000, hwdata=0xABABABAB, done_out 3 cycles late, stall held throughout.
- Load half to 0x0000_3001 -> misaligned_out=1 same cycle, htrans stays 00, stall_out=0.
- Load signed byte at 0x...02 with hresp=1/hready=0 then hresp=1/hready=1 -> ERR entered, bus_err_out=1 on second cycle, ahb_resp_out=1 in both, no done_out.
- hready held 0 in ADDR -> bus_err_out after 16 cycles, IDLE next cycle, htrans 00.
- rst_n_in low mid-DATA -> all outputs 0 asynchronously. After release, a new word load completes in 3 cycles.
